// File: rtl/mul_div_unit_pkg.sv
// Shared op codes, FSM state encoding and the restoring-divide step for the
// multi-cycle multiply/divide unit.
package mul_div_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [7:0] EXE_ADD_OP   = 8'b00100000;
    localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] rem;
        logic [XLEN-1:0] quot;
    } div_step_t;

    function automatic logic is_muldiv_op(input logic [7:0] op);
        return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) ||
               (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
    endfunction

    // One restoring iteration: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits.
    function automatic div_step_t div_step(input logic [XLEN-1:0] rem_in,
                                           input logic [XLEN-1:0] quot_in,
                                           input logic [XLEN-1:0] divisor_in);
        logic [XLEN:0] w_shift;
        logic [XLEN:0] w_diff;
        div_step_t     res;
        w_shift  = {rem_in, quot_in[XLEN-1]};
        w_diff   = w_shift - {1'b0, divisor_in};
        res.quot = {quot_in[XLEN-2:0], ~w_diff[XLEN]};
        res.rem  = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
        return res;
    endfunction

endpackage

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider on unsigned magnitudes; the first
// iteration is folded into the go cycle so fin rises 32 cycles after go.
module div_radix2
    import mul_div_unit_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            go,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem,
    output logic            fin
);

    localparam int unsigned CNT_W = 6;

    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_quot;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_div;
    logic             r_fin;
    div_step_t        w_first;
    div_step_t        w_next;

    assign w_first = div_step(XLEN'(0), dividend, divisor);
    assign w_next  = div_step(r_rem, r_quot, r_div);

    always_ff @(posedge clk) begin
        if (!resetn || abort) begin
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_fin  <= 1'b0;
        end else if (go) begin
            r_quot <= w_first.quot;
            r_rem  <= w_first.rem;
            r_div  <= divisor;
            r_cnt  <= CNT_W'(XLEN - 1);
            r_fin  <= 1'b0;
        end else if (r_cnt != '0) begin
            r_quot <= w_next.quot;
            r_rem  <= w_next.rem;
            r_cnt  <= r_cnt - CNT_W'(1);
            r_fin  <= (r_cnt == CNT_W'(1));
        end else begin
            r_fin  <= 1'b0;
        end
    end

    assign quot = r_quot;
    assign rem  = r_rem;
    assign fin  = r_fin;

endmodule

// File: rtl/mul_div_unit.sv
// Execute-stage multi-cycle MULT/MULTU/DIV/DIVU unit: stalls the pipe while
// busy and pulses done with the {hi,lo} result for the HI/LO write port.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned W       = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [7:0]   alucontrol,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         flush,
    output logic         stall,
    output logic         done,
    output logic [W-1:0] hi_out,
    output logic [W-1:0] lo_out
);

    localparam int unsigned CNT_W = 3;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_mcnt;
    logic [2*W-1:0]   r_pipe [MUL_LAT];
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_done;
    logic [W-1:0]     r_hi;
    logic [W-1:0]     r_lo;

    logic             w_accept;
    logic             w_div_go;
    logic             w_ld_mul;
    logic             w_ld_div;
    logic             w_ld_dz;
    logic             w_signed;
    logic             w_is_div;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [W-1:0]     w_a_mag;
    logic [W-1:0]     w_b_mag;
    logic [2*W-1:0]   w_a_ext;
    logic [2*W-1:0]   w_b_ext;
    logic [2*W-1:0]   w_prod;
    logic [W-1:0]     w_quot;
    logic [W-1:0]     w_rem;
    logic             w_fin;

    assign w_signed = (alucontrol == EXE_MULT_OP) || (alucontrol == EXE_DIV_OP);
    assign w_is_div = (alucontrol == EXE_DIV_OP)  || (alucontrol == EXE_DIVU_OP);
    assign w_a_neg  = w_signed & a[W-1];
    assign w_b_neg  = w_signed & b[W-1];
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;

    // Sign/zero extension lets one 64-bit truncated product serve both MULT and MULTU.
    assign w_a_ext  = {{W{w_a_neg}}, a};
    assign w_b_ext  = {{W{w_b_neg}}, b};
    assign w_prod   = w_a_ext * w_b_ext;

    div_radix2 u_div (
        .clk      (clk),
        .resetn   (resetn),
        .go       (w_div_go),
        .abort    (flush),
        .dividend (w_a_mag),
        .divisor  (w_b_mag),
        .quot     (w_quot),
        .rem      (w_rem),
        .fin      (w_fin)
    );

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_div_go     = 1'b0;
        w_ld_mul     = 1'b0;
        w_ld_div     = 1'b0;
        w_ld_dz      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && is_muldiv_op(alucontrol) && !flush) begin
                    w_accept = 1'b1;
                    if (!w_is_div) begin
                        w_state_next = ST_MUL;
                    end else if (b == '0) begin
                        w_state_next = ST_DONE;
                        w_ld_dz      = 1'b1;
                    end else begin
                        w_state_next = ST_DIV;
                        w_div_go     = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (flush) begin
                    w_state_next = ST_IDLE;
                end else if (r_mcnt == CNT_W'(MUL_LAT - 1)) begin
                    w_state_next = ST_DONE;
                    w_ld_mul     = 1'b1;
                end
            end
            ST_DIV: begin
                if (flush) begin
                    w_state_next = ST_IDLE;
                end else if (w_fin) begin
                    w_state_next = ST_DONE;
                    w_ld_div     = 1'b1;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
        stall = w_accept || (r_state == ST_MUL) || (r_state == ST_DIV);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_mcnt  <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_ld_mul | w_ld_div | w_ld_dz;
            if (w_accept) begin
                r_mcnt  <= '0;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
            end else if (r_state == ST_MUL) begin
                r_mcnt  <= r_mcnt + CNT_W'(1);
            end
            if (w_ld_dz) begin
                r_hi <= a;
                r_lo <= '1;
            end else if (w_ld_mul) begin
                {r_hi, r_lo} <= r_pipe[MUL_LAT-1];
            end else if (w_ld_div) begin
                r_hi <= r_neg_r ? -w_rem  : w_rem;
                r_lo <= r_neg_q ? -w_quot : w_quot;
            end
        end
    end

    // Stage 0 captures the product at accept and then holds; later stages are retiming slack.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < MUL_LAT; i++) r_pipe[i] <= '0;
        end else begin
            if (w_accept) r_pipe[0] <= w_prod;
            for (int unsigned i = 1; i < MUL_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign done   = r_done;
    assign hi_out = r_hi;
    assign lo_out = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected {hi,lo} and done cycle are
// queued at accept and checked whenever done pulses.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    localparam int unsigned MUL_LAT = 2;
    localparam int unsigned W       = 32;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [7:0]   alucontrol;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         stall;
    logic         done;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [63:0] last_res = 64'd0;
    logic [7:0]  ops [4] = '{EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP};

    mul_div_unit #(.MUL_LAT(MUL_LAT), .W(W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .alucontrol (alucontrol),
        .a          (a),
        .b          (b),
        .flush      (flush),
        .stall      (stall),
        .done       (done),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] x,
                                          input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (op == EXE_MULT_OP) begin
            p = 64'(sx * sy);
        end else if (op == EXE_MULTU_OP) begin
            p = {32'd0, x} * {32'd0, y};
        end else if (y == 32'd0) begin
            p = {x, 32'hFFFF_FFFF};
        end else if (op == EXE_DIV_OP) begin
            q = sx / sy;
            r = sx % sy;
            p = {r[31:0], q[31:0]};
        end else begin
            p = {x % y, x / y};
        end
        return p;
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", 64'(done), 64'd0);
            end else begin : pop_blk
                exp_t e;
                e = sb_q.pop_front();
                check("result", {hi_out, lo_out}, e.res);
                check("latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Issue one op, holding start high until done as a stalled pipe would.
    task automatic issue(input logic [7:0] op, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [63:0] exp_res);
        int lat;
        if (op == EXE_MULT_OP || op == EXE_MULTU_OP) lat = int'(MUL_LAT) + 1;
        else if (ib == 32'd0)                        lat = 1;
        else                                         lat = 33;
        start      = 1'b1;
        alucontrol = op;
        a          = ia;
        b          = ib;
        @(negedge clk);
        check("stall_accept", 64'(stall), 64'd1);
        sb_q.push_back('{exp_res, cyc + lat});
        @(posedge clk); #1;
        a = $urandom;
        b = $urandom;
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            check("stall_busy", 64'(stall), 64'd1);
        end
        @(negedge clk);
        check("stall_done", 64'(stall), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("no_reissue", 64'(stall), 64'd0);
        check("drained", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
        last_res = exp_res;
        @(posedge clk); #1;
    endtask

    initial begin
        resetn     = 1'b0;
        start      = 1'b0;
        flush      = 1'b0;
        alucontrol = 8'd0;
        a          = '0;
        b          = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi_out), 64'd0);
        check("rst_lo", 64'(lo_out), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;

        issue(EXE_MULT_OP,  32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(EXE_MULTU_OP, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE);
        issue(EXE_DIV_OP,   32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(EXE_DIVU_OP,  32'd100,       32'd0, 64'h0000_0064_FFFF_FFFF);
        issue(EXE_DIV_OP,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        issue(EXE_DIV_OP,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);

        // Flush at DIV iteration 10: no done, outputs keep the previous result.
        start = 1'b1; alucontrol = EXE_DIVU_OP; a = 32'd1000; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("stall_flush_cycle", 64'(stall), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("stall_after_flush", 64'(stall), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("hold_after_flush", {hi_out, lo_out}, last_res);
        issue(EXE_MULT_OP, 32'd3, 32'd4, 64'd12);

        // Flush in the accept cycle blocks the accept.
        start = 1'b1; alucontrol = EXE_MULT_OP; a = 32'd5; b = 32'd6; flush = 1'b1;
        @(negedge clk);
        check("stall_flush_accept", 64'(stall), 64'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("idle_after_flush_accept", 64'(stall), 64'd0);
        @(posedge clk); #1;

        // Non mul/div op is ignored.
        start = 1'b1; alucontrol = EXE_ADD_OP; a = 32'd1; b = 32'd2;
        @(negedge clk);
        check("stall_add", 64'(stall), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("stall_add_next", 64'(stall), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin : rnd_blk
            logic [7:0]  op;
            logic [31:0] ra;
            logic [31:0] rb;
            op = ops[i % 4];
            ra = $urandom;
            rb = (i == 7) ? 32'd0 : ((i == 5) ? 32'($urandom_range(1, 100)) : $urandom);
            issue(op, ra, rb, model(op, ra, rb));
        end

        // Reset mid-DIV discards the op and clears the outputs.
        start = 1'b1; alucontrol = EXE_DIV_OP; a = 32'd50; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        check("rst_mid_hi", 64'(hi_out), 64'd0);
        check("rst_mid_lo", 64'(lo_out), 64'd0);
        check("rst_mid_stall", 64'(stall), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("rst_mid_quiet", {hi_out, lo_out}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
